bus_arbiter4: RTL and testbench
===============================

# bus_arbiter4

Round-robin arbiter that shares the 16-bit four-input select datapath between four requesters. It owns the 2-bit select, grants one requester at a time with a valid/ready handshake toward a single consumer, and holds the grant for a multi-beat burst. It sits between the four producer units and the shared result bus that feeds writeback.

## Interface
- HOLD_MAX, 8: maximum beats per grant before forced release; range 1..255; used only when ARB_HOLD_LIMIT_EN is defined.

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  4  per-requester request, bit i = requester i
- last  in  4  bit i high = current beat of requester i ends its burst
- data0..data3  in  16 each  requester data
- gnt  out  4  one-hot grant, registered
- sel  out  2  registered select driving the 4:1 data mux (0→data0 … 3→data3)
- out_data  out  16  selected data, combinational from sel
- out_valid  out  1  beat valid toward consumer
- out_ready  in  1  consumer accepts beat
- busy  out  1  high while in GRANT

## Operation
- States: IDLE, GRANT. Reset: state=IDLE, gnt=0, sel=0, busy=0, out_valid=0, rr pointer=3 (requester 0 has first priority), beat count=0.
- IDLE: if req≠0, pick the first set bit searching upward from pointer+1 mod 4; register gnt=one-hot(winner), sel=winner, go GRANT. If req=0, stay; outputs unchanged at zero.
- GRANT: out_valid = req[sel]; out_data = data[sel]; a beat transfers when out_valid && out_ready.
- Release (→IDLE, gnt=0, pointer=sel, count=0) on the first of:
  - transfer with last[sel]=1;
  - req[sel]=0 (requester abandons; no beat transferred that cycle);
  - transfer that brings beat count to HOLD_MAX (macro defined only).
- sel holds its last value in IDLE; out_valid=0 whenever gnt=0.
- Requests from non-granted requesters are ignored until re-arbitration; no preemption.
- Beat count: 8-bit, increments per transfer, cleared on release.

## Timing
- req→gnt latency: 1 cycle (req sampled in IDLE, gnt visible next cycle).
- Release bubble: 1 IDLE cycle between consecutive grants, even when other requests are pending.
- out_data/out_valid combinational from registered sel and live req/data; no added latency.
- Simultaneous requests: round-robin winner only; a requester that just released has lowest priority next arbitration.
- out_ready high with out_valid low: no transfer, no count change.
- rst_n asserted mid-burst: all outputs to reset values immediately (asynchronous); the partial burst is dropped, no beat transfers.

## Configuration
- ARB_HOLD_LIMIT_EN defined: grant forcibly released after HOLD_MAX transfers even without last; the requester must re-request to continue.
- Not defined: beat count not compared; grant held until last or req drop; HOLD_MAX ignored.

## Structure
- Shared package arb_pkg: NUM_REQ=4, DATA_W=16, SEL_W=2, state encoding (IDLE=0, GRANT=1).
- Sub-module rr_pick4: combinational; inputs req[3:0] and pointer[1:0]; outputs any, winner[1:0]. The FSM, counter and data selection live in bus_arbiter4.

## Test plan
- Reset, then req=4'b0001, last[0]=1, out_ready=1 → gnt=0001, sel=0 one cycle later; one beat of data0; gnt=0 the following cycle.
- req=4'b1111 continuously, single-beat bursts → grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Requester 2 bursts 3 beats with out_ready toggling 1,0,1,0,1 → exactly 3 transfers, gnt held until the 3rd, then released; pointer=2, next winner 3.
- ARB_HOLD_LIMIT_EN, HOLD_MAX=4, requester 1 never asserts last → release after 4th transfer; other pending requester granted next; without macro, the grant persists past 4 beats.
- Requester 0 drops req mid-burst → out_valid=0, gnt=0 next cycle, no extra transfer counted.
- rst_n low during GRANT → gnt=0, sel=0, out_valid=0, busy=0 immediately; after release, requester 0 has top priority.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared widths, requester count and FSM encoding for the four-way result-bus arbiter.
package arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction
endpackage

// File: rtl/rr_pick4.sv
// Round-robin pick: first set request bit searching upward from pointer+1 (mod 4).
// Purely combinational, zero latency; no flow control of its own.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   pointer,
    output logic               any,
    output logic [SEL_W-1:0]   winner
);
    logic [SEL_W-1:0] idx;

    // Scan from lowest to highest priority so the nearest requester overwrites last.
    always_comb begin
        any    = |req;
        winner = pointer;
        idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = pointer + SEL_W'(k);
            if (req[idx]) winner = idx;
        end
    end
endmodule

// File: rtl/bus_arbiter4.sv
// Four-way round-robin burst arbiter for the shared result bus; ARB_HOLD_LIMIT_EN caps beats per grant at HOLD_MAX.
// Grant registered 1 cycle after request, 1 idle bubble between grants; out_data/out_valid combinational from sel.
// Beats stall while out_ready is low; the grant is held until last, request drop or hold limit.
module bus_arbiter4
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  last,
    input  logic [DATA_W-1:0]   data0,
    input  logic [DATA_W-1:0]   data1,
    input  logic [DATA_W-1:0]   data2,
    input  logic [DATA_W-1:0]   data3,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [SEL_W-1:0]    sel,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);
    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               any;
    logic [SEL_W-1:0]   winner;
    logic               xfer;
    logic               hold_hit;

    rr_pick4 u_pick (
        .req     (req),
        .pointer (ptr_q),
        .any     (any),
        .winner  (winner)
    );

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign busy      = (state_q == GRANT);
    assign out_valid = busy && req[sel_q];
    assign xfer      = out_valid && out_ready;

`ifdef ARB_HOLD_LIMIT_EN
    assign hold_hit = ((cnt_q + 8'd1) == 8'(HOLD_MAX));
`else
    assign hold_hit = 1'b0;
`endif

    always_comb begin
        case (sel_q)
            2'd0:    out_data = data0;
            2'd1:    out_data = data1;
            2'd2:    out_data = data2;
            default: out_data = data3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = GRANT;
                    gnt_d   = onehot(winner);
                    sel_d   = winner;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                // An abandoned request releases without a beat; the releaser drops to lowest priority.
                if (!req[sel_q] || (xfer && (last[sel_q] || hold_hit))) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = sel_q;
                    cnt_d   = '0;
                end else if (xfer) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4: expected beats queued at stimulus time, popped by a negedge monitor.
module tb_bus_arbiter4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  last = '0;
    logic [15:0] d0 = 16'h0A00, d1 = 16'h1A00, d2 = 16'h2A00, d3 = 16'h3A00;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [17:0] exp_q[$];

    bus_arbiter4 #(.HOLD_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last),
        .data0(d0), .data1(d1), .data2(d2), .data3(d3),
        .gnt(gnt), .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push(input logic [1:0] s, input logic [15:0] v);
        exp_q.push_back({s, v});
    endtask

    task automatic do_reset();
        req = '0; last = '0; out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", {14'd0, sel, out_data}, 32'h0);
            end else begin
                chk("xfer", {14'd0, sel, out_data}, {14'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] eg;
        // Reset values
        mid();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        do_reset();

        // Single beat from requester 0
        push(2'd0, 16'h0A00);
        tick(); req = 4'b0001; last = 4'b0001; out_ready = 1'b1;
        mid(); chk("t1_lat_gnt", 32'(gnt), 32'h0);
        tick();
        mid(); chk("t1_gnt", 32'(gnt), 32'h1); chk("t1_sel", 32'(sel), 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        tick(); req = 4'b0000;
        mid(); chk("t1_rel_gnt", 32'(gnt), 32'h0); chk("t1_rel_busy", 32'(busy), 32'h0);

        // All four requesting, single-beat bursts
        do_reset();
        for (int k = 0; k < 5; k++) begin
            case (k % 4)
                0: push(2'd0, d0);
                1: push(2'd1, d1);
                2: push(2'd2, d2);
                default: push(2'd3, d3);
            endcase
        end
        tick(); req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            mid(); chk("t2_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
            tick();
            if (k == 4) req = 4'b0000;
            mid(); chk("t2_bubble", 32'(gnt), 32'h0);
        end

        // Requester 2: three beats with ready toggling, then requester 3 wins
        do_reset();
        push(2'd2, 16'h2000); push(2'd2, 16'h2001); push(2'd2, 16'h2002); push(2'd3, 16'h3A00);
        tick(); req = 4'b1100; last = 4'b0000; out_ready = 1'b1; d2 = 16'h2000;
        mid(); chk("t3_lat", 32'(gnt), 32'h0);
        tick();
        mid(); chk("t3_gnt0", 32'(gnt), 32'h4); chk("t3_sel", 32'(sel), 32'h2);
        tick(); out_ready = 1'b0;
        mid(); chk("t3_gnt1", 32'(gnt), 32'h4); chk("t3_valid_stall", 32'(out_valid), 32'h1);
        tick(); out_ready = 1'b1; d2 = 16'h2001;
        mid(); chk("t3_gnt2", 32'(gnt), 32'h4);
        tick(); out_ready = 1'b0;
        mid(); chk("t3_gnt3", 32'(gnt), 32'h4);
        tick(); out_ready = 1'b1; d2 = 16'h2002; last = 4'b0100;
        mid(); chk("t3_gnt4", 32'(gnt), 32'h4);
        tick(); last = 4'b1100;
        mid(); chk("t3_rel", 32'(gnt), 32'h0); chk("t3_rel_busy", 32'(busy), 32'h0);
        tick();
        mid(); chk("t3_next3", 32'(gnt), 32'h8); chk("t3_sel3", 32'(sel), 32'h3);
        tick(); req = 4'b0000;
        mid(); chk("t3_end", 32'(gnt), 32'h0);

        // Requester 1 never signals last; requester 2 pending
        do_reset();
        d2 = 16'h2A00;
`ifdef ARB_HOLD_LIMIT_EN
        for (int b = 0; b < 4; b++) push(2'd1, 16'h1000 + 16'(b));
`else
        for (int b = 0; b < 6; b++) push(2'd1, 16'h1000 + 16'(b));
`endif
        push(2'd2, 16'h2A00);
        tick(); req = 4'b0110; last = 4'b0100; out_ready = 1'b1;
        mid(); chk("t4_lat", 32'(gnt), 32'h0);
        for (int b = 0; b < 6; b++) begin
            tick(); d1 = 16'h1000 + 16'(b);
`ifdef ARB_HOLD_LIMIT_EN
            eg = (b < 4) ? 4'b0010 : ((b == 4) ? 4'b0000 : 4'b0100);
`else
            eg = 4'b0010;
`endif
            mid(); chk("t4_hold", 32'(gnt), 32'(eg));
        end
`ifdef ARB_HOLD_LIMIT_EN
        tick(); req = 4'b0000;
        mid(); chk("t4_end", 32'(gnt), 32'h0);
`else
        tick(); req = 4'b0100;
        mid(); chk("t4_drop_valid", 32'(out_valid), 32'h0); chk("t4_drop_gnt", 32'(gnt), 32'h2);
        tick();
        mid(); chk("t4_rel", 32'(gnt), 32'h0);
        tick();
        mid(); chk("t4_next2", 32'(gnt), 32'h4);
        tick(); req = 4'b0000;
        mid(); chk("t4_end", 32'(gnt), 32'h0);
`endif

        // Requester 0 abandons mid-burst
        do_reset();
        push(2'd0, 16'h0A01); push(2'd0, 16'h0A02);
        tick(); req = 4'b0001; last = 4'b0000; out_ready = 1'b1;
        mid(); chk("t5_lat", 32'(gnt), 32'h0);
        tick(); d0 = 16'h0A01;
        mid(); chk("t5_gnt_a", 32'(gnt), 32'h1);
        tick(); d0 = 16'h0A02;
        mid(); chk("t5_gnt_b", 32'(gnt), 32'h1);
        tick(); req = 4'b0000;
        mid(); chk("t5_valid", 32'(out_valid), 32'h0);
        tick();
        mid(); chk("t5_rel", 32'(gnt), 32'h0); chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_pending", 32'(exp_q.size()), 32'h0);

        // Asynchronous reset during a grant
        do_reset();
        tick(); req = 4'b0010; out_ready = 1'b0;
        mid(); chk("t6_lat", 32'(gnt), 32'h0);
        tick();
        mid(); chk("t6_gnt", 32'(gnt), 32'h2); chk("t6_sel", 32'(sel), 32'h1);
        tick(); rst_n = 1'b0;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 32'h0); chk("t6_rst_sel", 32'(sel), 32'h0);
        chk("t6_rst_valid", 32'(out_valid), 32'h0); chk("t6_rst_busy", 32'(busy), 32'h0);
        tick(); rst_n = 1'b1; req = 4'b0011;
        mid(); chk("t6_idle", 32'(gnt), 32'h0);
        tick();
        mid(); chk("t6_prio0", 32'(gnt), 32'h1);
        tick(); req = 4'b0000;
        tick();
        mid(); chk("t6_end", 32'(gnt), 32'h0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
